// File: rtl/alu_shift_pkg.sv
// Shared types and constants for the ALU shift scheduler.
package alu_shift_pkg;

    // Scheduler sequencing: accept, drive the shift unit, capture, respond
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    // ALU_FUN codes understood by the 1-bit shift unit
    localparam logic [3:0] SHIFT_FUN_SRL = 4'b1100;
    localparam logic [3:0] SHIFT_FUN_SLL = 4'b1101;

    // Direction bit (1 = left) to ALU_FUN code
    function automatic logic [3:0] shift_fun_sel(input logic dir);
        return dir ? SHIFT_FUN_SLL : SHIFT_FUN_SRL;
    endfunction

endpackage

// File: rtl/alu_shift_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr,
// wrapping around. Output is one-hot plus the encoded index; all zero
// when en is low or nobody requests.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] index
);

    // Candidate requester index for each search offset from ptr
    logic [IW-1:0] w_cand [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            assign w_cand[gi] = IW'((int'(ptr) + gi) % N);
        end
    endgenerate

    // Walk the candidates in rotating order and take the first valid one
    always_comb begin
        logic w_found;
        w_found = 1'b0;
        gnt     = '0;
        index   = '0;
        for (int k = 0; k < N; k++) begin
            if (en && !w_found && req[w_cand[k]]) begin
                w_found          = 1'b1;
                gnt[w_cand[k]]   = 1'b1;
                index            = w_cand[k];
            end
        end
    end

endmodule

// File: rtl/alu_shift_scheduler.sv
// ALU shift scheduler: shares the registered 1-bit shift unit between
// NUM_REQ requesters, expanding each multi-bit shift into repeated 1-bit
// operations and returning the final value with the requester id.
// Optional build macro ALU_SHIFT_SCHED_ROTATE_EN adds req_rot, which turns
// a command into a rotate by re-inserting the ejected bit on each step.
module alu_shift_scheduler
    import alu_shift_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 2,
    parameter int CNT_WIDTH  = 4,
    parameter int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]              req_dir,
    input  logic [NUM_REQ*CNT_WIDTH-1:0]    req_amt,
`ifdef ALU_SHIFT_SCHED_ROTATE_EN
    input  logic [NUM_REQ-1:0]              req_rot,
`endif
    output logic [DATA_WIDTH-1:0]           shift_a,
    output logic [3:0]                      shift_fun,
    output logic                            shift_en,
    input  logic [DATA_WIDTH-1:0]           shift_out,
    input  logic                            shift_flag,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic [IDW-1:0]                  rsp_id,
    output logic                            rsp_err,
    output logic                            busy
);

    // Remaining-iteration counter must hold both any amount and DATA_WIDTH
    localparam int CLAMP_W = $clog2(DATA_WIDTH + 1);
    localparam int REM_W   = (CNT_WIDTH > CLAMP_W) ? CNT_WIDTH : CLAMP_W;

    sched_state_t           r_state;
    sched_state_t           w_state_next;

    logic [DATA_WIDTH-1:0]  r_work;
    logic                   r_dir;
    logic [REM_W-1:0]       r_rem;
    logic [IDW-1:0]         r_id;
    logic                   r_err;
    logic                   r_rot;
    logic [IDW-1:0]         r_rr_ptr;

    logic [DATA_WIDTH-1:0]  w_data_arr [NUM_REQ];
    logic [CNT_WIDTH-1:0]   w_amt_arr  [NUM_REQ];
    logic [NUM_REQ-1:0]     w_rot_vec;

    logic                   w_arb_en;
    logic [NUM_REQ-1:0]     w_gnt;
    logic [IDW-1:0]         w_gnt_idx;
    logic                   w_accept;
    logic [REM_W-1:0]       w_sel_amt;
    logic [REM_W-1:0]       w_sel_rem;
    logic [IDW-1:0]         w_ptr_next;
    logic                   w_eject;
    logic [DATA_WIDTH-1:0]  w_rot_fill;
    logic [DATA_WIDTH-1:0]  w_capture;

    // Unpack the flat request buses into per-requester views
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_amt_arr[gi]  = req_amt[gi*CNT_WIDTH +: CNT_WIDTH];
        end
    endgenerate

`ifdef ALU_SHIFT_SCHED_ROTATE_EN
    assign w_rot_vec = req_rot;
`else
    assign w_rot_vec = '0;
`endif

    // Grants only happen in IDLE and never while reset is held
    assign w_arb_en = (r_state == IDLE) && rst;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (r_rr_ptr),
        .en    (w_arb_en),
        .gnt   (w_gnt),
        .index (w_gnt_idx)
    );

    assign req_ready = w_gnt;
    assign w_accept  = |w_gnt;

    // Amounts at or beyond the operand width would shift everything out,
    // so iterations are capped at DATA_WIDTH
    assign w_sel_amt = REM_W'(w_amt_arr[w_gnt_idx]);
    assign w_sel_rem = (w_sel_amt >= REM_W'(DATA_WIDTH)) ? REM_W'(DATA_WIDTH) : w_sel_amt;

    assign w_ptr_next = (w_gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IDW'(1);

    // Bit that leaves the operand this step: MSB on a left shift, LSB on right
    assign w_eject    = r_dir ? r_work[DATA_WIDTH-1] : r_work[0];
    assign w_rot_fill = !r_rot ? '0 :
                        r_dir  ? {{(DATA_WIDTH-1){1'b0}}, w_eject} :
                                 {w_eject, {(DATA_WIDTH-1){1'b0}}};
    assign w_capture  = shift_out | w_rot_fill;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and shift-unit / response output drive
    always_comb begin
        w_state_next = r_state;
        shift_en     = 1'b0;
        shift_a      = '0;
        shift_fun    = '0;
        rsp_valid    = 1'b0;
        rsp_data     = '0;
        rsp_id       = '0;
        rsp_err      = 1'b0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_accept) begin
                    w_state_next = (w_sel_rem == '0) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                shift_en     = 1'b1;
                shift_a      = r_work;
                shift_fun    = shift_fun_sel(r_dir);
                w_state_next = WAIT;
            end
            WAIT: begin
                // Operand and function held while the unit's result settles
                shift_en     = 1'b1;
                shift_a      = r_work;
                shift_fun    = shift_fun_sel(r_dir);
                w_state_next = (r_rem == REM_W'(1)) ? RESP : ISSUE;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = r_work;
                rsp_id    = r_id;
                rsp_err   = r_err;
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Command latch on accept, partial-result capture on each WAIT cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_work   <= '0;
            r_dir    <= 1'b0;
            r_rem    <= '0;
            r_id     <= '0;
            r_err    <= 1'b0;
            r_rot    <= 1'b0;
            r_rr_ptr <= '0;
        end else if (r_state == IDLE) begin
            if (w_accept) begin
                r_work   <= w_data_arr[w_gnt_idx];
                r_dir    <= req_dir[w_gnt_idx];
                r_rem    <= w_sel_rem;
                r_id     <= w_gnt_idx;
                r_err    <= 1'b0;
                r_rot    <= w_rot_vec[w_gnt_idx];
                r_rr_ptr <= w_ptr_next;
            end
        end else if (r_state == WAIT) begin
            r_work <= w_capture;
            r_err  <= r_err | ~shift_flag;
            r_rem  <= r_rem - REM_W'(1);
        end
    end

endmodule
